multicycle_control_unit: RTL and testbench

Sequencing control unit for the 32-bit multi-cycle MIPS datapath.
- Replaces per-instruction combinational decode with a Moore/Mealy FSM.
- Steps each instruction through fetch, decode, execute, memory and writeback, stalling on a memory ready handshake.
- Flags illegal opcodes and, optionally, memory timeouts, by entering a sticky fault state.
- Sits between the instruction register (opcode source) and the datapath muxes, register file, ALU control and memory port.

---
 rtl/mcu_pkg.sv | 57 +++++
 rtl/mcu_opcode_decode.sv | 32 +++
 rtl/multicycle_control_unit.sv | 149 ++++++++++++++
 tb/tb_multicycle_control_unit.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/mcu_pkg.sv
// Shared types and encodings for the multi-cycle MIPS control unit.
package mcu_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC     = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_LUI_WB   = 4'd10,
    S_FAULT    = 4'd11
  } state_t;

  // opcodes (IR[31:26])
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_JAL = 6'b000011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_JR  = 6'b001000;
  localparam logic [5:0] OP_LUI = 6'b001111;

  // datapath mux encodings
  localparam logic [1:0] RD_RT = 2'b00, RD_RD = 2'b01, RD_RA = 2'b10;
  localparam logic [1:0] M2R_ALU = 2'b00, M2R_MDR = 2'b01, M2R_PC = 2'b10;
  localparam logic [1:0] SRCB_B = 2'b00, SRCB_4 = 2'b01, SRCB_IMM = 2'b10, SRCB_IMM_SH = 2'b11;
  localparam logic [1:0] ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_FUNCT = 2'b10;
  localparam logic [1:0] PCS_ALU = 2'b00, PCS_ALUOUT = 2'b01, PCS_JUMP = 2'b10, PCS_A = 2'b11;

  // decoded instruction class plus the sticky datapath qualifiers
  typedef struct packed {
    logic       ld;
    logic       st;
    logic       r;
    logic       beq;
    logic       jmp;       // j, jal or jr
    logic       jal;
    logic       jr;
    logic       lui;
    logic       extended;
    logic [1:0] load;
    logic       illegal;
  } opdec_t;

endpackage

// File: rtl/mcu_opcode_decode.sv
// Combinational opcode classifier: instruction-class one-hots plus
// extended/load/lui qualifiers and an illegal-opcode flag.
module mcu_opcode_decode
  import mcu_pkg::*;
(
  input  logic [5:0] opcode,
  output opdec_t     dec
);

  // one case arm per legal opcode, everything else is illegal
  always_comb begin
    dec = '0;
    case (opcode)
      OP_LB:  dec.ld = 1'b1;
      OP_LH:  begin dec.ld = 1'b1; dec.load = 2'b10; end
      OP_LW:  begin dec.ld = 1'b1; dec.load = 2'b01; dec.extended = 1'b1; end
      OP_LBU: begin dec.ld = 1'b1; dec.extended = 1'b1; end
      OP_LHU: begin dec.ld = 1'b1; dec.load = 2'b10; dec.extended = 1'b1; end
      OP_SB:  begin dec.st = 1'b1; dec.extended = 1'b1; end
      OP_SH:  begin dec.st = 1'b1; dec.extended = 1'b1; end
      OP_SW:  begin dec.st = 1'b1; dec.extended = 1'b1; end
      OP_R:   dec.r = 1'b1;
      OP_J:   dec.jmp = 1'b1;
      OP_JAL: begin dec.jmp = 1'b1; dec.jal = 1'b1; end
      OP_BEQ: dec.beq = 1'b1;
      OP_JR:  begin dec.jmp = 1'b1; dec.jr = 1'b1; end
      OP_LUI: dec.lui = 1'b1;
      default: dec.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle MIPS sequencing FSM: fetch/decode/execute/memory/writeback
// with mem_ready stalls and a sticky FAULT state for illegal opcodes.
// Optional feature: define MCU_TIMEOUT_EN to fault after MEM_TIMEOUT
// consecutive stalled cycles in a memory state.
module multicycle_control_unit
  import mcu_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       ir_write,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic [1:0] reg_dest,
  output logic [1:0] mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       extended,
  output logic       lui_ctrl,
  output logic [1:0] load,
  output logic       instr_done,
  output logic       fault
);

  state_t     state, nxt;
  logic [5:0] op_q;
  opdec_t     dq, dr;   // decode of latched op_q / raw IR opcode
  logic       tmo;      // stall limit hit this cycle

  mcu_opcode_decode u_dec_q (.opcode(op_q),   .dec(dq));
  mcu_opcode_decode u_dec_r (.opcode(opcode), .dec(dr));

  logic unused_dec;
`ifdef MCU_TIMEOUT_EN
  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  logic [CW-1:0] wait_cnt;
  logic          waiting;

  assign waiting = (state == S_FETCH || state == S_MEM_RD || state == S_MEM_WR) && !mem_ready;
  // the MEM_TIMEOUT-th consecutive low cycle is the one that faults
  assign tmo     = waiting && (wait_cnt == CW'(MEM_TIMEOUT - 1));

  // consecutive-stall counter; any completion or state change clears it
  always_ff @(posedge clk) begin
    if (rst || !waiting) wait_cnt <= '0;
    else                 wait_cnt <= wait_cnt + 1'b1;
  end

  assign unused_dec = ^{dq.st, dq.r, dq.beq, dq.jmp, dq.illegal,
                        dr.jal, dr.jr, dr.lui, dr.extended, dr.load};
`else
  assign tmo        = 1'b0;
  assign unused_dec = ^{dq.st, dq.r, dq.beq, dq.jmp, dq.illegal,
                        dr.jal, dr.jr, dr.lui, dr.extended, dr.load, (MEM_TIMEOUT > 0)};
`endif

  // state and latched opcode; reset overrides any wait or FAULT
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_FETCH;
      op_q  <= '0;
    end else begin
      state <= nxt;
      if (state == S_DECODE) op_q <= opcode;
    end
  end

  // next-state sequencing
  always_comb begin
    nxt = state;
    case (state)
      S_FETCH:    if (mem_ready) nxt = S_DECODE; else if (tmo) nxt = S_FAULT;
      S_DECODE: begin
        if (dr.illegal)         nxt = S_FAULT;
        else if (dr.ld || dr.st) nxt = S_MEM_ADDR;
        else if (dr.r)           nxt = S_EXEC;
        else if (dr.beq)         nxt = S_BRANCH;
        else if (dr.jmp)         nxt = S_JUMP;
        else                     nxt = S_LUI_WB;
      end
      S_MEM_ADDR: nxt = dq.ld ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   if (mem_ready) nxt = S_MEM_WB; else if (tmo) nxt = S_FAULT;
      S_MEM_WR:   if (mem_ready) nxt = S_FETCH;  else if (tmo) nxt = S_FAULT;
      S_EXEC:     nxt = S_R_WB;
      S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_LUI_WB: nxt = S_FETCH;
      S_FAULT:    nxt = S_FAULT;
      default:    nxt = S_FAULT;
    endcase
  end

  // per-state outputs; everything forced low while rst is high
  always_comb begin
    pc_write = 1'b0; pc_write_cond = 1'b0; ir_write = 1'b0; i_or_d = 1'b0;
    mem_read = 1'b0; mem_write = 1'b0; reg_write = 1'b0;
    reg_dest = RD_RT; mem_to_reg = M2R_ALU; alu_src_a = 1'b0;
    alu_src_b = SRCB_B; alu_op = ALU_ADD; pc_source = PCS_ALU;
    extended = 1'b0; lui_ctrl = 1'b0; load = 2'b00;
    instr_done = 1'b0; fault = 1'b0;
    if (!rst) begin
      if (state != S_FAULT) begin
        extended = dq.extended;
        lui_ctrl = dq.lui;
        load     = dq.load;
      end
      case (state)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = SRCB_4;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        S_DECODE:   alu_src_b = SRCB_IMM_SH;
        S_MEM_ADDR: begin alu_src_a = 1'b1; alu_src_b = SRCB_IMM; end
        S_MEM_RD:   begin i_or_d = 1'b1; mem_read = 1'b1; end
        S_MEM_WB: begin
          reg_write = 1'b1; reg_dest = RD_RT; mem_to_reg = M2R_MDR; instr_done = 1'b1;
        end
        S_MEM_WR:   begin i_or_d = 1'b1; mem_write = 1'b1; instr_done = mem_ready; end
        S_EXEC:     begin alu_src_a = 1'b1; alu_src_b = SRCB_B; alu_op = ALU_FUNCT; end
        S_R_WB: begin
          reg_write = 1'b1; reg_dest = RD_RD; mem_to_reg = M2R_ALU; instr_done = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a = 1'b1; alu_op = ALU_SUB; pc_write_cond = 1'b1;
          pc_source = PCS_ALUOUT; instr_done = 1'b1;
        end
        S_JUMP: begin
          pc_write   = 1'b1;
          pc_source  = dq.jr ? PCS_A : PCS_JUMP;
          instr_done = 1'b1;
          if (dq.jal) begin reg_write = 1'b1; reg_dest = RD_RA; mem_to_reg = M2R_PC; end
        end
        S_LUI_WB:   begin reg_write = 1'b1; reg_dest = RD_RT; instr_done = 1'b1; end
        S_FAULT:    fault = 1'b1;
        default:    fault = 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: an instruction-level model expands each
// instruction into its expected per-cycle output vectors (with randomized
// memory stalls), then a driver replays them against the DUT.
module tb_multicycle_control_unit;

  localparam int TMO = 4;

  typedef struct packed {
    logic       pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write, reg_write;
    logic [1:0] reg_dest, mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic       extended, lui_ctrl;
    logic [1:0] load;
    logic       instr_done, fault;
  } outs_t;

  typedef struct {
    logic       r;
    logic [5:0] op;
    logic       rdy;
    outs_t      e;
    string      tag;
  } step_t;

  logic clk = 1'b0, rst = 1'b1, mem_ready = 1'b0;
  logic [5:0] opcode = '0;
  logic pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write, reg_write;
  logic [1:0] reg_dest, mem_to_reg, alu_src_b, alu_op, pc_source, load;
  logic alu_src_a, extended, lui_ctrl, instr_done, fault;
  outs_t got;

  int checks = 0, failures = 0;
  step_t q[$];
  logic [5:0] mop;   // model of the instruction currently held for sticky outputs
  logic [5:0] legal [14];

  multicycle_control_unit #(.MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .ir_write(ir_write),
    .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
    .reg_write(reg_write), .reg_dest(reg_dest), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .extended(extended), .lui_ctrl(lui_ctrl),
    .load(load), .instr_done(instr_done), .fault(fault)
  );

  assign got = {pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write, reg_write,
                reg_dest, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source,
                extended, lui_ctrl, load, instr_done, fault};

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit is_load(input logic [5:0] o);
    return o inside {6'b100000, 6'b100001, 6'b100011, 6'b100100, 6'b100101};
  endfunction
  function automatic bit is_store(input logic [5:0] o);
    return o inside {6'b101000, 6'b101001, 6'b101011};
  endfunction

  // sticky qualifiers derived from the held instruction
  function automatic outs_t base();
    outs_t o = '0;
    o.extended = (mop inside {6'b100011, 6'b100101, 6'b100100, 6'b101011, 6'b101001, 6'b101000});
    o.lui_ctrl = (mop == 6'b001111);
    o.load     = {(mop == 6'b100001 || mop == 6'b100101), (mop == 6'b100011)};
    return o;
  endfunction

  task automatic push(input string tag, input logic r, input logic [5:0] op,
                      input logic rdy, input outs_t e);
    step_t s;
    s.r = r; s.op = op; s.rdy = rdy; s.e = e; s.tag = tag;
    q.push_back(s);
  endtask

  task automatic push_reset();
    push("reset", 1'b1, 6'($urandom), 1'($urandom), '0);
    mop = '0;
  endtask

  task automatic gen_fault(input int n);
    outs_t o = '0;
    o.fault = 1'b1;
    for (int i = 0; i < n; i++) push("fault", 1'b0, 6'($urandom), 1'($urandom), o);
    push_reset();
  endtask

  // one memory access: w stalled cycles then the completing cycle
  task automatic mem_access(input string tag, input outs_t wo, input outs_t done_o,
                            input int w, output bit flt);
    flt = 1'b0;
    for (int i = 0; i < w; i++) begin
      push({tag, "_wait"}, 1'b0, 6'($urandom), 1'b0, wo);
`ifdef MCU_TIMEOUT_EN
      if (i + 1 == TMO) begin flt = 1'b1; return; end
`endif
    end
    push(tag, 1'b0, 6'($urandom), 1'b1, done_o);
  endtask

  task automatic gen_instr(input logic [5:0] op, input int wf, input int wm, input int nflt);
    outs_t o, d;
    bit flt;
    o = base(); o.mem_read = 1'b1; o.alu_src_b = 2'b01;
    d = o; d.ir_write = 1'b1; d.pc_write = 1'b1;
    mem_access("fetch", o, d, wf, flt);
    if (flt) begin gen_fault(5); return; end
    o = base(); o.alu_src_b = 2'b11;
    push("decode", 1'b0, op, 1'($urandom), o);
    mop = op;
    if (is_load(op) || is_store(op)) begin
      o = base(); o.alu_src_a = 1'b1; o.alu_src_b = 2'b10;
      push("mem_addr", 1'b0, 6'($urandom), 1'($urandom), o);
      if (is_load(op)) begin
        o = base(); o.i_or_d = 1'b1; o.mem_read = 1'b1;
        mem_access("mem_rd", o, o, wm, flt);
        if (flt) begin gen_fault(5); return; end
        o = base(); o.reg_write = 1'b1; o.mem_to_reg = 2'b01; o.instr_done = 1'b1;
        push("mem_wb", 1'b0, 6'($urandom), 1'($urandom), o);
      end else begin
        o = base(); o.i_or_d = 1'b1; o.mem_write = 1'b1;
        d = o; d.instr_done = 1'b1;
        mem_access("mem_wr", o, d, wm, flt);
        if (flt) begin gen_fault(5); return; end
      end
    end else begin
      o = base();
      case (op)
        6'b000000: begin
          o.alu_src_a = 1'b1; o.alu_op = 2'b10;
          push("exec", 1'b0, 6'($urandom), 1'($urandom), o);
          o = base(); o.reg_write = 1'b1; o.reg_dest = 2'b01; o.instr_done = 1'b1;
          push("r_wb", 1'b0, 6'($urandom), 1'($urandom), o);
        end
        6'b000100: begin
          o.alu_src_a = 1'b1; o.alu_op = 2'b01; o.pc_write_cond = 1'b1;
          o.pc_source = 2'b01; o.instr_done = 1'b1;
          push("branch", 1'b0, 6'($urandom), 1'($urandom), o);
        end
        6'b000010, 6'b000011, 6'b001000: begin
          o.pc_write = 1'b1; o.instr_done = 1'b1;
          o.pc_source = (op == 6'b001000) ? 2'b11 : 2'b10;
          if (op == 6'b000011) begin o.reg_write = 1'b1; o.reg_dest = 2'b10; o.mem_to_reg = 2'b10; end
          push("jump", 1'b0, 6'($urandom), 1'($urandom), o);
        end
        6'b001111: begin
          o.reg_write = 1'b1; o.instr_done = 1'b1;
          push("lui_wb", 1'b0, 6'($urandom), 1'($urandom), o);
        end
        default: gen_fault(nflt);
      endcase
    end
  endtask

  initial begin
    logic [5:0] op;
    step_t s;
    legal = '{6'b100000, 6'b100001, 6'b100011, 6'b100100, 6'b100101, 6'b101000, 6'b101001,
              6'b101011, 6'b000000, 6'b000010, 6'b000011, 6'b000100, 6'b001000, 6'b001111};
    mop = '0;
    push_reset();
    push_reset();
    gen_instr(6'b000000, 0, 0, 0);     // add, zero-wait: 4 cycles
    gen_instr(6'b100101, 0, 3, 0);     // lhu, 3 stalls in MEM_RD: 8 cycles
    gen_instr(6'b000011, 0, 0, 0);     // jal
    gen_instr(6'b001000, 1, 0, 0);     // jr after a fetch stall
    gen_instr(6'b001111, 0, 0, 0);     // lui
    gen_instr(6'b000100, 0, 0, 0);     // beq
    gen_instr(6'b111111, 0, 0, 20);    // illegal: sticky fault then reset
    gen_instr(6'b100011, 0, 3, 0);     // lw stalled in MEM_RD, reset mid-wait
    void'(q.pop_back());
    void'(q.pop_back());
    push_reset();
    gen_instr(6'b101011, 0, TMO, 0);   // sw, stall length equal to the timeout
    gen_instr(6'b101011, 0, TMO - 1, 0); // sw, ready on the last allowed cycle
    repeat (200) begin
      if ($urandom_range(9) == 0) op = 6'($urandom);
      else op = legal[$urandom_range(13)];
      gen_instr(op, $urandom_range(0, 2), $urandom_range(0, 5), 3);
    end

    while (q.size() > 0) begin
      s = q.pop_front();
      @(posedge clk);
      #1;
      rst = s.r; opcode = s.op; mem_ready = s.rdy;
      @(negedge clk);
      chk(s.tag, 32'(got), 32'(s.e));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
